hazard_ctrl_unit: RTL and testbench
===================================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter FWD_EN, default 1: 1 = full EX/MEM and MEM/WB forwarding; 0 = no forwarding, stall-on-RAW.
REQ-003 SHALL have parameter BR_STAGE, default 3: stage resolving branches, 2 = EX, 3 = MEM.
REQ-004 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-005 SHALL use one clock; reset is asynchronous and active-high. Ports: clk input 1 rising-edge clock; reset input 1 async active-high reset.
REQ-006 SHALL have the following ID-stage ports:
- id_valid input 1: ID holds a real instruction.
- id_rs1, id_rs2 input REG_ADDR_W: ID source indices.
- id_use_rs1, id_use_rs2 input 1: source is actually read.
REQ-007 SHALL have the following downstream-stage ports:
- ex_rd input REG_ADDR_W; ex_regwrite input 1; ex_memread input 1: ID/EX contents.
- mem_rd input REG_ADDR_W; mem_regwrite input 1: EX/MEM contents.
- wb_rd input REG_ADDR_W; wb_regwrite input 1: MEM/WB contents.
- br_taken input 1: branch at BR_STAGE resolved taken.
- cnt_clr input 1: synchronous counter clear.
REQ-008 SHALL have the following control outputs:
- pc_stall output 1; ifid_stall output 1; idex_bubble output 1.
- ifid_flush, idex_flush, exmem_flush output 1 each.
- fwd_a_sel, fwd_b_sel output 2, registered: EX operand source; 00 = register file, 01 = MEM/WB, 10 = EX/MEM.
- id_wb_byp_a, id_wb_byp_b output 1: ID read must take the WB write data.
- stall_cnt, flush_cnt output CNT_W.

Function
REQ-009 SHALL treat a hazard on a source only when id_valid, use bit set, index nonzero, and the producer's regwrite is set with matching rd.
REQ-010 FWD_EN=1 SHALL raise load_use when ex_memread and the EX producer hazards either source; MEM and WB matches raise no stall.
REQ-011 FWD_EN=0 SHALL raise load_use-equivalent stall when either source hazards EX or MEM producer.
REQ-012 On stall, SHALL assert pc_stall, ifid_stall and idex_bubble combinationally in the same cycle.
REQ-013 br_taken SHALL override stall: all stall outputs 0 that cycle.
REQ-014 br_taken with BR_STAGE=3 SHALL assert ifid_flush, idex_flush and exmem_flush; with BR_STAGE=2 SHALL assert ifid_flush and idex_flush only. Flushes are combinational, one cycle per br_taken cycle.
REQ-015 fwd_x_sel SHALL update every clock edge as follows (x = a/b, per source):
- br_taken, stall, FWD_EN=0 or no hazard: load 00.
- Else EX-producer match: load 10, since that result sits in EX/MEM next cycle; EX beats MEM.
- Else MEM-producer match: load 01.
REQ-016 id_wb_byp_x SHALL be combinational: source hazards WB producer and no EX/MEM match, independent of FWD_EN.
REQ-017 stall_cnt SHALL increment once per stalled cycle; flush_cnt once per br_taken cycle; both saturate at all-ones, never wrap.
REQ-018 cnt_clr SHALL zero both counters at the next edge, overriding that cycle's increment.
REQ-019 Repeated stalls SHALL persist while the condition holds; no internal timeout.

Reset
REQ-020 reset SHALL asynchronously force fwd_a_sel=fwd_b_sel=00 and stall_cnt=flush_cnt=0.
REQ-021 Combinational outputs SHALL follow inputs during reset; reset mid-stall leaves no residual state after release.

Structure
REQ-022 SHALL take fwd-select encodings (FWD_RF, FWD_MEMWB, FWD_EXMEM) and default REG_ADDR_W from shared package pipeline_pkg.
REQ-023 SHALL instantiate sub-module raw_match per (source, producer) pair: index, use, producer rd, regwrite -> hit.
REQ-024 SHALL be 120-400 lines of RTL; no memories.

Verification
REQ-025 FWD_EN=1, EX holds ld x5 (ex_memread=1), ID add uses rs1=x5 -> stall outputs 1 for one cycle, stall_cnt=1; next cycle mem_rd=5 -> fwd_a_sel=01 after edge.
REQ-026 FWD_EN=1, ex_rd=7 ex_regwrite=1, ID rs2=7 -> no stall, fwd_b_sel=10 after edge; with also mem_rd=7 -> still 10.
REQ-027 FWD_EN=0, mem_rd=3 regwrite, ID rs1=3 -> stall asserted; fwd_a_sel stays 00; wb_rd=3 only -> id_wb_byp_a=1, no stall.
REQ-028 BR_STAGE=3, br_taken=1 concurrent with load-use -> three flushes 1, stall outputs 0, flush_cnt+1, fwd sels 00; BR_STAGE=2 -> exmem_flush=0.
REQ-029 rd=0 producers, CNT_W=4 forced 20 stalls, then cnt_clr -> no hazard on x0; stall_cnt holds 15, then 0.
REQ-030 reset asserted mid-stall with fwd_a_sel=10 -> fwd_a_sel=00 and counters 0 immediately, without clock edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: operand-forwarding encodings, producer stage indices,
// and the priority rule that picks a forwarding source.
package pipeline_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  // Producer slots as seen from ID: the youngest writer sits in ID/EX.
  localparam int P_EX  = 0;
  localparam int P_MEM = 1;
  localparam int P_WB  = 2;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  // Select for the operand one cycle from now; the EX producer is younger and wins.
  function automatic fwd_sel_e next_fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit) return FWD_EXMEM;
    if (mem_hit) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/raw_match.sv
// Read-after-write detector for one (source, producer) pair; purely combinational.
// Latency: zero cycles. Backpressure: none, it only reports a hit.
module raw_match
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] src_idx,
  input  logic                  src_use,
  input  logic [REG_ADDR_W-1:0] prod_rd,
  input  logic                  prod_we,
  output logic                  hit
);

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  assign hit = src_use && prod_we && (src_idx != '0) && (src_idx == prod_rd);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: stalls, branch flushes, forwarding selects and event counters.
// Latency: stall/flush/bypass combinational, fwd selects and counters registered; stalls hold as long as the hazard does.
module hazard_ctrl_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int FWD_EN     = 1,
  parameter int BR_STAGE   = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite,
  input  logic                  br_taken,
  input  logic                  cnt_clr,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  id_wb_byp_a,
  output logic                  id_wb_byp_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic [REG_ADDR_W-1:0] prod_rd [3];
  logic [2:0]            prod_we;
  logic [2:0]            hit_a;
  logic [2:0]            hit_b;
  logic                  stall_raw;
  logic                  stall;

  fwd_sel_e              fwd_a_d, fwd_a_q;
  fwd_sel_e              fwd_b_d, fwd_b_q;
  logic [CNT_W-1:0]      stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0]      flush_cnt_d, flush_cnt_q;

  assign prod_rd[P_EX]  = ex_rd;
  assign prod_rd[P_MEM] = mem_rd;
  assign prod_rd[P_WB]  = wb_rd;
  assign prod_we        = {wb_regwrite, mem_regwrite, ex_regwrite};

  for (genvar p = 0; p < 3; p++) begin : g_prod
    raw_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_a (
      .src_idx (id_rs1),
      .src_use (id_valid && id_use_rs1),
      .prod_rd (prod_rd[p]),
      .prod_we (prod_we[p]),
      .hit     (hit_a[p])
    );
    raw_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_b (
      .src_idx (id_rs2),
      .src_use (id_valid && id_use_rs2),
      .prod_rd (prod_rd[p]),
      .prod_we (prod_we[p]),
      .hit     (hit_b[p])
    );
  end

  // Without forwarding, any in-flight producer ahead of WB must drain before ID reads.
  always_comb begin
    stall_raw = 1'b0;
    if (FWD_EN != 0) begin
      stall_raw = ex_memread && (hit_a[P_EX] || hit_b[P_EX]);
    end else begin
      stall_raw = hit_a[P_EX] || hit_a[P_MEM] || hit_b[P_EX] || hit_b[P_MEM];
    end
  end

  assign stall       = stall_raw && !br_taken;
  assign pc_stall    = stall;
  assign ifid_stall  = stall;
  assign idex_bubble = stall;

  assign ifid_flush  = br_taken;
  assign idex_flush  = br_taken;
  assign exmem_flush = (BR_STAGE == 3) && br_taken;

  assign id_wb_byp_a = hit_a[P_WB] && !hit_a[P_EX] && !hit_a[P_MEM];
  assign id_wb_byp_b = hit_b[P_WB] && !hit_b[P_EX] && !hit_b[P_MEM];

  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if ((FWD_EN != 0) && !br_taken && !stall) begin
      fwd_a_d = next_fwd_sel(hit_a[P_EX], hit_a[P_MEM]);
      fwd_b_d = next_fwd_sel(hit_b[P_EX], hit_b[P_MEM]);
    end
  end

  // Clear beats increment; counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (br_taken && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two configurations (forwarding/MEM-branch and no-forwarding/EX-branch)
// share one stimulus stream and are checked each cycle against a stage-distance model.
module tb_hazard_ctrl_unit;

  localparam int RW  = 5;
  localparam int CW  = 4;
  localparam int CAP = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_use_rs1, id_use_rs2;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic          ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
  logic          br_taken, cnt_clr;

  logic          pcs_o [2];
  logic          ifs_o [2];
  logic          idb_o [2];
  logic          iff_o [2];
  logic          ixf_o [2];
  logic          emf_o [2];
  logic          bypa_o [2];
  logic          bypb_o [2];
  logic [1:0]    fsa_o [2];
  logic [1:0]    fsb_o [2];
  logic [CW-1:0] sc_o [2];
  logic [CW-1:0] fc_o [2];

  int checks = 0;
  int errors = 0;

  int m_fa [2];
  int m_fb [2];
  int m_sc [2];
  int m_fc [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hazard_ctrl_unit #(
      .REG_ADDR_W (RW),
      .FWD_EN     ((g == 0) ? 1 : 0),
      .BR_STAGE   ((g == 0) ? 3 : 2),
      .CNT_W      (CW)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .ex_rd        (ex_rd),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .br_taken     (br_taken),
      .cnt_clr      (cnt_clr),
      .pc_stall     (pcs_o[g]),
      .ifid_stall   (ifs_o[g]),
      .idex_bubble  (idb_o[g]),
      .ifid_flush   (iff_o[g]),
      .idex_flush   (ixf_o[g]),
      .exmem_flush  (emf_o[g]),
      .fwd_a_sel    (fsa_o[g]),
      .fwd_b_sel    (fsb_o[g]),
      .id_wb_byp_a  (bypa_o[g]),
      .id_wb_byp_b  (bypb_o[g]),
      .stall_cnt    (sc_o[g]),
      .flush_cnt    (fc_o[g])
    );
  end

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d got=%0d want=%0d t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  // Distance to the nearest in-flight writer of r: 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB, 3 = none.
  function automatic int nearest(input logic [RW-1:0] r, input logic u);
    if (!id_valid || !u || r == 0) return 3;
    if (ex_regwrite && ex_rd == r) return 0;
    if (mem_regwrite && mem_rd == r) return 1;
    if (wb_regwrite && wb_rd == r) return 2;
    return 3;
  endfunction

  function automatic bit m_stall(input int i);
    int na, nb;
    bit s;
    na = nearest(id_rs1, id_use_rs1);
    nb = nearest(id_rs2, id_use_rs2);
    if (i == 0) s = ex_memread && (na == 0 || nb == 0);
    else        s = (na < 2) || (nb < 2);
    return s && !br_taken;
  endfunction

  function automatic int m_sel(input int i, input int n);
    if (i != 0 || br_taken || m_stall(i)) return 0;
    if (n == 0) return 2;
    if (n == 1) return 1;
    return 0;
  endfunction

  function automatic int cap(input int v);
    return (v > CAP) ? CAP : v;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_fa[i] <= 0; m_fb[i] <= 0; m_sc[i] <= 0; m_fc[i] <= 0;
      end else begin
        m_fa[i] <= m_sel(i, nearest(id_rs1, id_use_rs1));
        m_fb[i] <= m_sel(i, nearest(id_rs2, id_use_rs2));
        if (cnt_clr) begin
          m_sc[i] <= 0; m_fc[i] <= 0;
        end else begin
          m_sc[i] <= m_sc[i] + int'(m_stall(i));
          m_fc[i] <= m_fc[i] + int'(br_taken);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int st;
      st = int'(m_stall(i));
      chk("pc_stall", i, int'(pcs_o[i]), st);
      chk("ifid_stall", i, int'(ifs_o[i]), st);
      chk("idex_bubble", i, int'(idb_o[i]), st);
      chk("ifid_flush", i, int'(iff_o[i]), int'(br_taken));
      chk("idex_flush", i, int'(ixf_o[i]), int'(br_taken));
      chk("exmem_flush", i, int'(emf_o[i]), (i == 0) ? int'(br_taken) : 0);
      chk("byp_a", i, int'(bypa_o[i]), int'(nearest(id_rs1, id_use_rs1) == 2));
      chk("byp_b", i, int'(bypb_o[i]), int'(nearest(id_rs2, id_use_rs2) == 2));
      chk("fwd_a", i, int'(fsa_o[i]), reset ? 0 : m_fa[i]);
      chk("fwd_b", i, int'(fsb_o[i]), reset ? 0 : m_fb[i]);
      chk("stall_cnt", i, int'(sc_o[i]), reset ? 0 : cap(m_sc[i]));
      chk("flush_cnt", i, int'(fc_o[i]), reset ? 0 : cap(m_fc[i]));
    end
  end

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    br_taken = 0; cnt_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1;
    idle();
    step(); step();
    chk("rst_fwd_a", 0, int'(fsa_o[0]), 0);
    chk("rst_stall_cnt", 0, int'(sc_o[0]), 0);
    reset = 0;

    // load-use on rs1, then the load moves to EX/MEM
    id_valid = 1; id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 1; id_use_rs2 = 1;
    ex_rd = 5; ex_regwrite = 1; ex_memread = 1;
    #3;
    chk("lu_pc_stall", 0, int'(pcs_o[0]), 1);
    chk("lu_ifid_stall", 0, int'(ifs_o[0]), 1);
    chk("lu_idex_bubble", 0, int'(idb_o[0]), 1);
    step();
    ex_rd = 0; ex_regwrite = 0; ex_memread = 0; mem_rd = 5; mem_regwrite = 1;
    #3;
    chk("lu_cnt", 0, int'(sc_o[0]), 1);
    chk("lu_released", 0, int'(pcs_o[0]), 0);
    step();
    #3;
    chk("lu_fwd_a", 0, int'(fsa_o[0]), 1);

    // ALU producer in EX feeds rs2; EX wins over a MEM match
    idle(); id_valid = 1; id_rs2 = 7; id_use_rs2 = 1; ex_rd = 7; ex_regwrite = 1;
    #3;
    chk("alu_no_stall", 0, int'(pcs_o[0]), 0);
    step();
    #3;
    chk("alu_fwd_b", 0, int'(fsb_o[0]), 2);
    mem_rd = 7; mem_regwrite = 1;
    step();
    #3;
    chk("alu_fwd_b_pri", 0, int'(fsb_o[0]), 2);

    // no-forwarding config: MEM producer stalls, WB producer bypasses
    idle(); id_valid = 1; id_rs1 = 3; id_use_rs1 = 1; mem_rd = 3; mem_regwrite = 1;
    #3;
    chk("nf_stall", 1, int'(pcs_o[1]), 1);
    step();
    #3;
    chk("nf_fwd_a", 1, int'(fsa_o[1]), 0);
    mem_regwrite = 0; wb_rd = 3; wb_regwrite = 1;
    #1;
    chk("nf_byp_a", 1, int'(bypa_o[1]), 1);
    chk("nf_wb_no_stall", 1, int'(pcs_o[1]), 0);

    // branch taken during load-use
    idle(); id_valid = 1; id_rs1 = 9; id_use_rs1 = 1; ex_rd = 9; ex_regwrite = 1; cnt_clr = 1;
    step();
    cnt_clr = 0; ex_memread = 1; br_taken = 1;
    #3;
    chk("br_ifid_flush", 0, int'(iff_o[0]), 1);
    chk("br_idex_flush", 0, int'(ixf_o[0]), 1);
    chk("br_exmem_flush3", 0, int'(emf_o[0]), 1);
    chk("br_exmem_flush2", 1, int'(emf_o[1]), 0);
    chk("br_stall_ovr", 0, int'(pcs_o[0]), 0);
    chk("br_stall_ovr", 1, int'(idb_o[1]), 0);
    step();
    #3;
    chk("br_fwd_a", 0, int'(fsa_o[0]), 0);
    chk("br_flush_cnt", 0, int'(fc_o[0]), 1);
    chk("br_stall_cnt", 0, int'(sc_o[0]), 0);

    // x0 never hazards; saturation then clear
    idle(); id_valid = 1; id_use_rs1 = 1; ex_regwrite = 1; ex_memread = 1;
    #3;
    chk("x0_no_stall", 0, int'(pcs_o[0]), 0);
    chk("x0_no_stall", 1, int'(pcs_o[1]), 0);
    id_rs1 = 5; ex_rd = 5;
    repeat (20) step();
    #3;
    chk("sat_stall_cnt", 0, int'(sc_o[0]), 15);
    cnt_clr = 1;
    step();
    #3;
    chk("clr_stall_cnt", 0, int'(sc_o[0]), 0);
    cnt_clr = 0;

    // reset in the middle of a stall with fwd_a at EX/MEM
    idle(); id_valid = 1; id_rs1 = 9; id_use_rs1 = 1; ex_rd = 9; ex_regwrite = 1;
    step();
    ex_memread = 1;
    #2;
    chk("pre_rst_fwd_a", 0, int'(fsa_o[0]), 2);
    reset = 1;
    #1;
    chk("arst_fwd_a", 0, int'(fsa_o[0]), 0);
    chk("arst_stall_cnt", 0, int'(sc_o[0]), 0);
    chk("arst_flush_cnt", 0, int'(fc_o[0]), 0);
    chk("arst_comb_stall", 0, int'(pcs_o[0]), 1);
    step();
    reset = 0;
    idle();
    step();

    for (int c = 0; c < 3000; c++) begin
      id_valid     = ($urandom_range(0, 7) != 0);
      id_rs1       = RW'($urandom_range(0, 3));
      id_rs2       = RW'($urandom_range(0, 3));
      id_use_rs1   = $urandom_range(0, 1) == 1;
      id_use_rs2   = $urandom_range(0, 1) == 1;
      ex_rd        = RW'($urandom_range(0, 3));
      ex_regwrite  = $urandom_range(0, 1) == 1;
      ex_memread   = $urandom_range(0, 1) == 1;
      mem_rd       = RW'($urandom_range(0, 3));
      mem_regwrite = $urandom_range(0, 1) == 1;
      wb_rd        = RW'($urandom_range(0, 3));
      wb_regwrite  = $urandom_range(0, 1) == 1;
      br_taken     = ($urandom_range(0, 7) == 0);
      cnt_clr      = ($urandom_range(0, 63) == 0);
      reset        = ($urandom_range(0, 255) == 0);
      step();
    end
    reset = 0;
    idle();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
